// File: rtl/alu_seq_hs.sv
//------------------------------------------------------------------------------
// Module   : alu_seq_hs
// Purpose  : Registered signed ALU with valid/ready handshakes on both sides.
//            Seven ops (SUB, NAND, LONES, ADD, MUL, SHL, ABS) selected by a
//            3-bit opcode; one operation in flight at a time. Single-cycle ops
//            produce a result one cycle after accept; MUL is an iterative
//            shift-add multiplier with WIDTH+1 cycles of latency.
// Config   : ALU_MUL_EN - when defined, op 100 is the iterative multiplier and
//            the BUSY state exists; when undefined, op 100 is reserved (err).
// Ports    : i_clk, i_rst (sync, active-high)
//            i_valid/o_ready, i_oper[2:0], i_arg0/i_arg1[WIDTH-1:0] - request
//            o_valid/i_ready, o_result[WIDTH-1:0], o_flag[3:0]       - response
//            o_flag = {overflow, pos, neg, err}
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq_hs #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_oper,
   input  logic [WIDTH-1:0] i_arg0,
   input  logic [WIDTH-1:0] i_arg1,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic [3:0]       o_flag
);

   localparam logic [WIDTH-1:0] c_SHMAX = WIDTH'(WIDTH - 1);

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flag;

   logic             w_accept;
   logic             w_is_mul;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;
   logic             w_err;
   logic [3:0]       w_flg;
   logic [WIDTH-1:0] w_lones;
   logic             w_run;
   logic [2*WIDTH-1:0] w_sh;

   // Error suppresses every other flag; neg/pos are both clear for zero.
   function automatic logic [3:0] f_flags(input logic [WIDTH-1:0] res,
                                          input logic ovf, input logic err);
      if (err) return 4'b0001;
      return {ovf, ~res[WIDTH-1] & (res != '0), res[WIDTH-1], 1'b0};
   endfunction

   assign o_valid  = (r_state == HOLD);
   assign o_ready  = (r_state == IDLE) | ((r_state == HOLD) & i_ready);
   assign w_accept = i_valid & o_ready;
   assign o_result = r_result;
   assign o_flag   = r_flag;

`ifdef ALU_MUL_EN
   assign w_is_mul = (i_oper == 3'b100);
`else
   assign w_is_mul = 1'b0;
`endif

   // Single-cycle datapath, evaluated on the live inputs and captured at accept.
   always_comb begin
      w_res   = '0;
      w_ovf   = 1'b0;
      w_err   = 1'b0;
      w_lones = '0;
      w_run   = 1'b1;
      // Sign-extended A shifted left; the shift is lossless only if the
      // top WIDTH+1 bits all equal the new sign bit.
      w_sh    = {{WIDTH{i_arg0[WIDTH-1]}}, i_arg0} << i_arg1;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (w_run && i_arg0[i]) w_lones = w_lones + 1'b1;
         else                    w_run   = 1'b0;
      end
      case (i_oper)
         3'b000: begin
            w_res = i_arg0 - i_arg1;
            w_ovf = (i_arg0[WIDTH-1] != i_arg1[WIDTH-1]) &&
                    (w_res[WIDTH-1] != i_arg0[WIDTH-1]);
         end
         3'b001: w_res = ~(i_arg0 & i_arg1);
         3'b010: w_res = w_lones;
         3'b011: begin
            w_res = i_arg0 + i_arg1;
            w_ovf = (i_arg0[WIDTH-1] == i_arg1[WIDTH-1]) &&
                    (w_res[WIDTH-1] != i_arg0[WIDTH-1]);
         end
         3'b101: begin
            if (i_arg1[WIDTH-1] || (i_arg1 > c_SHMAX)) begin
               w_err = 1'b1;
            end else begin
               w_res = w_sh[WIDTH-1:0];
               w_ovf = (w_sh[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){w_sh[WIDTH-1]}});
            end
         end
         3'b110: begin
            w_res = i_arg0[WIDTH-1] ? (~i_arg0 + 1'b1) : i_arg0;
            // Most negative value negates to itself.
            w_ovf = i_arg0[WIDTH-1] & w_res[WIDTH-1];
         end
         default: w_err = 1'b1;
      endcase
      if (w_err) begin
         w_res = '0;
         w_ovf = 1'b0;
      end
      w_flg = f_flags(w_res, w_ovf, w_err);
   end

`ifdef ALU_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH+1:0] r_mcand;
   logic [WIDTH:0]     r_mplier;
   logic [2*WIDTH+1:0] r_prod;
   logic               r_neg;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH:0]     w_a_ext;
   logic [WIDTH:0]     w_b_ext;
   logic [WIDTH:0]     w_a_mag;
   logic [WIDTH:0]     w_b_mag;
   logic [2*WIDTH+1:0] w_p_sgn;
   logic               w_p_ovf;
   logic               w_mul_done;

   assign w_a_ext    = {i_arg0[WIDTH-1], i_arg0};
   assign w_b_ext    = {i_arg1[WIDTH-1], i_arg1};
   assign w_a_mag    = i_arg0[WIDTH-1] ? (~w_a_ext + 1'b1) : w_a_ext;
   assign w_b_mag    = i_arg1[WIDTH-1] ? (~w_b_ext + 1'b1) : w_b_ext;
   assign w_p_sgn    = r_neg ? (~r_prod + 1'b1) : r_prod;
   // Product fits iff everything above the result's sign bit is sign extension.
   assign w_p_ovf    = (w_p_sgn[2*WIDTH+1:WIDTH-1] != {(WIDTH+3){w_p_sgn[WIDTH-1]}});
   // WIDTH add steps are done at cnt 0..WIDTH-1; the extra cycle registers the result.
   assign w_mul_done = (r_cnt == CW'(WIDTH));
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_accept) begin
`ifdef ALU_MUL_EN
            w_next = w_is_mul ? BUSY : HOLD;
`else
            w_next = HOLD;
`endif
         end
`ifdef ALU_MUL_EN
         BUSY: if (w_mul_done) w_next = HOLD;
`endif
         HOLD: if (i_ready) begin
            if (!w_accept) w_next = IDLE;
`ifdef ALU_MUL_EN
            else           w_next = w_is_mul ? BUSY : HOLD;
`else
            else           w_next = HOLD;
`endif
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_result <= '0;
         r_flag   <= '0;
`ifdef ALU_MUL_EN
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
`endif
      end else begin
         r_state <= w_next;
         if (w_accept && !w_is_mul) begin
            r_result <= w_res;
            r_flag   <= w_flg;
         end
`ifdef ALU_MUL_EN
         if (w_accept && w_is_mul) begin
            r_mcand  <= {{(WIDTH+1){1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_prod   <= '0;
            r_neg    <= i_arg0[WIDTH-1] ^ i_arg1[WIDTH-1];
            r_cnt    <= '0;
         end else if (r_state == BUSY) begin
            if (w_mul_done) begin
               r_result <= w_p_sgn[WIDTH-1:0];
               r_flag   <= f_flags(w_p_sgn[WIDTH-1:0], w_p_ovf, 1'b0);
            end else begin
               if (r_mplier[0]) r_prod <= r_prod + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule

`default_nettype wire
